// File: rtl/lcd_pixel_source_if.sv
// Pixel handshake between the PPU fetcher (master) and the LCD pixel source (slave).
// A pixel moves on a dot tick when pix_valid and pix_ready are both high.
interface lcd_pixel_source_if #(
    parameter int DATA_W = 15
) ();
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;

    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready
    );
endinterface

// File: rtl/lcd_pixel_source.sv
// Game Boy line/frame timing generator: drives mode/ly/clkena/data towards the LCD
// and pulls one pixel per dot tick from the fetcher during mode 3.
module lcd_pixel_source #(
    parameter int DATA_W       = 15,
    parameter int LINE_DOTS    = 456,
    parameter int OAM_DOTS     = 80,
    parameter int XFER_DELAY   = 12,
    parameter int VIS_LINES    = 144,
    parameter int TOT_LINES    = 154,
    parameter int UNDERRUN_DOT = 447
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk4_en,
    input  logic                lcd_on,
    lcd_pixel_source_if.slave   pix,
    output logic [DATA_W-1:0]   data,
    output logic                clkena,
    output logic [1:0]          mode,
    output logic [7:0]          ly,
    output logic                vblank_irq,
    output logic                underrun
);

    localparam logic [8:0] DOT_LAST   = 9'(LINE_DOTS - 1);
    localparam logic [8:0] XFER_BEGIN = 9'(OAM_DOTS);
    localparam logic [8:0] XFER_FIRST = 9'(OAM_DOTS + XFER_DELAY);
    localparam logic [8:0] DOT_UNDER  = 9'(UNDERRUN_DOT);
    localparam logic [7:0] LINE_LAST  = 8'(TOT_LINES - 1);
    localparam logic [7:0] LINE_VBL   = 8'(VIS_LINES);
    localparam logic [7:0] PIX_LINE   = 8'd160;

    typedef enum logic [2:0] {
        S_OFF,
        S_OAM,
        S_XFER,
        S_HBLANK,
        S_VBLANK
    } state_t;

    state_t     state, state_nxt;
    logic [8:0] dot, dot_nxt;
    logic [7:0] line, line_nxt;
    logic [7:0] pcount, pcount_inc;
    logic [1:0] mode_nxt;
    logic       ready;
    logic       xfer;
    logic       underrun_hit;

    // Counter look-ahead: where the next tick will land
    always_comb begin
        dot_nxt  = dot + 9'd1;
        line_nxt = line;
        if (dot == DOT_LAST) begin
            dot_nxt  = 9'd0;
            line_nxt = (line == LINE_LAST) ? 8'd0 : line + 8'd1;
        end
    end

    assign xfer         = ready && pix.pix_valid && clk4_en;
    assign pcount_inc   = pcount + {7'd0, xfer};
    assign underrun_hit = clk4_en && (state == S_XFER) && (dot == DOT_UNDER)
                          && (pcount_inc < PIX_LINE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_OFF;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!lcd_on) begin
            state_nxt = S_OFF;
        end else if (clk4_en) begin
            if (line_nxt >= LINE_VBL)
                state_nxt = S_VBLANK;
            else if (dot_nxt < XFER_BEGIN)
                state_nxt = S_OAM;
            else if (dot_nxt == XFER_BEGIN)
                state_nxt = S_XFER;
            else if ((state == S_XFER) && ((pcount_inc == PIX_LINE) || (dot == DOT_UNDER)))
                state_nxt = S_HBLANK;
        end
    end

    // Ready is a pure function of registered state so the fetcher sees it a full cycle early
    always_comb begin
        case (state_nxt)
            S_OAM:    mode_nxt = 2'b10;
            S_XFER:   mode_nxt = 2'b11;
            S_VBLANK: mode_nxt = 2'b01;
            default:  mode_nxt = 2'b00;
        endcase
        ready = (state == S_XFER) && (dot >= XFER_FIRST) && (dot <= DOT_UNDER)
                && (pcount < PIX_LINE);
    end

    assign pix.pix_ready = ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dot        <= DOT_LAST;
            line       <= LINE_LAST;
            pcount     <= 8'd0;
            mode       <= 2'b00;
            ly         <= 8'd0;
            data       <= '0;
            clkena     <= 1'b0;
            vblank_irq <= 1'b0;
            underrun   <= 1'b0;
        end else if (!lcd_on) begin
            // Display off: park counters so the first tick after enable starts line 0
            dot        <= DOT_LAST;
            line       <= LINE_LAST;
            pcount     <= 8'd0;
            mode       <= 2'b00;
            ly         <= LINE_LAST;
            clkena     <= 1'b0;
            vblank_irq <= 1'b0;
        end else begin
            vblank_irq <= 1'b0;
            if (clk4_en) begin
                dot        <= dot_nxt;
                line       <= line_nxt;
                ly         <= line_nxt;
                mode       <= mode_nxt;
                clkena     <= xfer;
                pcount     <= (dot_nxt == XFER_BEGIN) ? 8'd0 : pcount_inc;
                vblank_irq <= (line_nxt == LINE_VBL) && (dot_nxt == 9'd0);
                if (xfer)
                    data <= pix.pix_data;
                if (underrun_hit)
                    underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_pixel_source.sv
// Randomised bench for lcd_pixel_source: a dot/line reference model feeds a per-cycle
// expectation queue that an independent monitor compares against the DUT outputs.
module tb_lcd_pixel_source;

    localparam int VIS = 8;
    localparam int TOT = 11;

    typedef struct {
        int          edge_no;
        logic [1:0]  mode;
        logic [7:0]  ly;
        logic        clkena;
        logic [14:0] data;
        logic        irq;
        logic        under;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk4_en;
    logic        lcd_on;
    logic [14:0] data;
    logic        clkena;
    logic [1:0]  mode;
    logic [7:0]  ly;
    logic        vblank_irq;
    logic        underrun;

    lcd_pixel_source_if #(.DATA_W(15)) pif ();

    lcd_pixel_source #(
        .VIS_LINES(VIS),
        .TOT_LINES(TOT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk4_en    (clk4_en),
        .lcd_on     (lcd_on),
        .pix        (pif.slave),
        .data       (data),
        .clkena     (clkena),
        .mode       (mode),
        .ly         (ly),
        .vblank_irq (vblank_irq),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int   edges = 0;
    always @(posedge clk) edges <= edges + 1;

    exp_t exp_q[$];
    exp_t cur;
    int   n_chk = 0, n_fail = 0;
    int   m_dot, m_ly, m_pc, ticks = 0;
    bit   m_off, m_ended, prev_tick = 1'b0;
    int   w_ly = -1, w_lo = 0, w_hi = 0;
    bit   v_rand = 1'b0, v_ramp = 1'b1;
    int   irq_seen = 0, irq_exp = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endfunction

    function automatic void model_reset();
        m_dot   = 455;
        m_ly    = TOT - 1;
        m_pc    = 0;
        m_off   = 1'b1;
        m_ended = 1'b1;
        cur     = '{edge_no: 0, mode: 2'b00, ly: 8'd0, clkena: 1'b0, data: 15'd0,
                    irq: 1'b0, under: 1'b0};
    endfunction

    // A line may accept pixels from dot 92 to dot 447 while fewer than 160 have gone out
    function automatic bit m_ready();
        return !m_off && (m_ly < VIS) && !m_ended && (m_dot >= 92) && (m_dot <= 447);
    endfunction

    task automatic step();
        bit          tick, valid, rdy, acc;
        logic [14:0] d;
        exp_t        e;
        tick      = !prev_tick && ($urandom_range(0, 9) != 0);
        prev_tick = tick;
        valid     = v_rand ? ($urandom_range(0, 99) < 85) : 1'b1;
        if (m_ly == w_ly && m_dot >= w_lo && m_dot < w_hi) valid = 1'b0;
        d = v_ramp ? 15'(m_pc) : 15'($urandom);
        clk4_en       = tick;
        pif.pix_valid = valid;
        pif.pix_data  = d;
        rdy = m_ready();
        chk("pix_ready", {31'd0, pif.pix_ready}, {31'd0, rdy});
        if (!lcd_on) begin
            m_off = 1'b1; m_dot = 455; m_ly = TOT - 1; m_pc = 0; m_ended = 1'b1;
            cur.mode = 2'b00; cur.ly = 8'(TOT - 1); cur.clkena = 1'b0; cur.irq = 1'b0;
        end else begin
            cur.irq = 1'b0;
            if (tick) begin
                acc = valid && rdy;
                cur.clkena = acc;
                if (acc) begin
                    cur.data = d;
                    m_pc++;
                end
                if (!m_off && m_ly < VIS && m_dot >= 80 && !m_ended) begin
                    if (m_pc == 160) m_ended = 1'b1;
                    else if (m_dot == 447) begin
                        m_ended   = 1'b1;
                        cur.under = 1'b1;
                    end
                end
                if (m_dot == 455) begin
                    m_dot = 0;
                    m_ly  = (m_ly == TOT - 1) ? 0 : m_ly + 1;
                end else m_dot++;
                m_off = 1'b0;
                if (m_dot == 80) begin
                    m_pc = 0;
                    m_ended = 1'b0;
                end
                cur.irq = (m_ly == VIS) && (m_dot == 0);
                if (cur.irq) irq_exp++;
                cur.mode = (m_ly >= VIS) ? 2'b01 : (m_dot < 80) ? 2'b10 :
                           !m_ended ? 2'b11 : 2'b00;
                cur.ly = 8'(m_ly);
                ticks++;
            end
        end
        e = cur;
        e.edge_no = edges + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(int tly, int tdot);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(m_ly == tly && m_dot == tdot) && n < 30000);
        if (n >= 30000) chk("run_to timeout", 32'd1, 32'd0);
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, " mode"},       {30'd0, mode},       32'd0);
        chk({tag, " ly"},         {24'd0, ly},         32'd0);
        chk({tag, " data"},       {17'd0, data},       32'd0);
        chk({tag, " clkena"},     {31'd0, clkena},     32'd0);
        chk({tag, " pix_ready"},  {31'd0, pif.pix_ready}, 32'd0);
        chk({tag, " vblank_irq"}, {31'd0, vblank_irq}, 32'd0);
        chk({tag, " underrun"},   {31'd0, underrun},   32'd0);
    endtask

    // Monitor: compares DUT outputs with the expectation for each clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (vblank_irq === 1'b1) irq_seen++;
            if (exp_q.size() > 0 && exp_q[0].edge_no == edges) begin
                e = exp_q.pop_front();
                chk("mode",       {30'd0, mode},       {30'd0, e.mode});
                chk("ly",         {24'd0, ly},         {24'd0, e.ly});
                chk("clkena",     {31'd0, clkena},     {31'd0, e.clkena});
                chk("data",       {17'd0, data},       {17'd0, e.data});
                chk("vblank_irq", {31'd0, vblank_irq}, {31'd0, e.irq});
                chk("underrun",   {31'd0, underrun},   {31'd0, e.under});
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        reset_n = 1'b0; lcd_on = 1'b0; clk4_en = 1'b0;
        pif.pix_valid = 1'b0; pif.pix_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        lcd_on  = 1'b1;
        reset_n = 1'b1;

        // Unstalled ramp lines through a full frame and the wrap back to line 0
        run_to(VIS, 0);
        run_to(0, 0);

        // 20-tick stall in mode 3 of line 2
        w_ly = 2; w_lo = 150; w_hi = 170;
        run_to(3, 0);

        // Line 4: the 160th pixel lands exactly on the last allowed dot
        w_ly = 4; w_lo = 0; w_hi = 288;
        run_to(5, 0);
        chk("underrun after dot-447 completion", {31'd0, underrun}, 32'd0);

        // Line 5: fetcher stops at dot 100, forcing an underrun
        w_ly = 5; w_lo = 100; w_hi = 456;
        run_to(6, 0);
        chk("underrun after starved line", {31'd0, underrun}, 32'd1);

        // Random stalls until mid-transfer of line 3 in the next frame, then display off
        w_ly = -1; v_rand = 1'b1; v_ramp = 1'b0;
        run_to(3, 150);
        lcd_on = 1'b0;
        t0 = ticks;
        repeat (2400) step();
        lcd_on = 1'b1;
        run_to(1, 200);

        // Asynchronous reset mid-line
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async reset");
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset_n = 1'b1;
        run_to(1, 0);

        chk("vblank_irq pulse count", 32'(irq_seen), 32'(irq_exp));
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
